vpd_access_engine: RTL

//   Hardware side of the PCIe VPD capability handshake. Holds the VPD Address

---
 rtl/vpd_access_engine.sv | 70 +++++++
 1 files changed

// File: rtl/vpd_access_engine.sv
// vpd_access_engine: VPD address/data registers and the variable-latency storage handshake behind them
module vpd_access_engine #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_addr_we,
    input  logic [15:0]       cfg_addr_wdata,
    input  logic              cfg_data_we,
    input  logic [DATA_W-1:0] cfg_data_wdata,
    input  logic [3:0]        cfg_byte_en,
    input  logic              err_clr,
    output logic [15:0]       vpd_addr_reg,
    output logic [DATA_W-1:0] vpd_data_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    state_t            state, state_d;
    logic [15:0]       addr_q;
    logic [DATA_W-1:0] data_q, be_mask;
    logic [CW-1:0]     cnt;
    logic              err_q, idle, done, abort;
    // an ack on the terminal count is a normal completion, so abort requires no ack
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < 4; i++) be_mask[8*i +: 8] = {8{cfg_byte_en[i]}};
        idle    = state == IDLE;
        done    = !idle && mem_ack;
        abort   = !idle && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
        state_d = idle ? (cfg_addr_we ? (cfg_addr_wdata[15] ? WR_WAIT : RD_WAIT) : IDLE)
                       : ((done || abort) ? IDLE : state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (idle && cfg_data_we) data_q <= (data_q & ~be_mask) | (cfg_data_wdata & be_mask);
            if (idle && cfg_addr_we) addr_q <= cfg_addr_wdata;
            if (done || abort) addr_q[15] <= state == RD_WAIT;
            if ((done || abort) && state == RD_WAIT) data_q <= done ? mem_rdata : '1;
            cnt   <= idle ? '0 : cnt + 1'b1;
            err_q <= abort ? 1'b1 : (err_clr ? 1'b0 : err_q);
        end
    end
    assign vpd_addr_reg = addr_q;
    assign vpd_data_reg = data_q;
    assign mem_req      = !idle;
    assign busy         = !idle;
    assign mem_we       = state == WR_WAIT;
    assign mem_addr     = addr_q[ADDR_W-1:2];
    assign mem_wdata    = data_q;
    assign timeout_err  = err_q;
endmodule
